// File: rtl/load_frame_pkg.sv
`default_nettype none
//==============================================================================
// Module  : load_frame_pkg
// Desc    : Shared FSM states, frame-start defaults and gray expansion helper.
// Rev     : 1.0 - initial release
//==============================================================================
package load_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2,
    ST_FLUSH = 2'd3
  } lfState_t;

  localparam int c_FS_X_DEFAULT = 143;
  localparam int c_FS_Y_DEFAULT = 34;

  // Gray byte widens to 10 bits by repeating its top bits into the LSBs.
  localparam int         c_GRAY_EXP_BITS = 2;
  localparam logic [9:0] c_BORDER_RGB    = 10'h3FF;

  function automatic logic [9:0] grayTo10(input logic [7:0] g);
    return {g, g[7 -: c_GRAY_EXP_BITS]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lf_delay_line.sv
`default_nettype none
//==============================================================================
// Module  : lf_delay_line
// Desc    : Fixed-depth shift register with asynchronous active-low clear.
// Rev     : 1.0 - initial release
//==============================================================================
module lf_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= iD;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign oQ = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/load_frame.sv
`default_nettype none
//==============================================================================
// Module  : load_frame
// Desc    : Replays a stored grayscale frame into a window of a live raster.
// Options : LOAD_FRAME_BORDER_EN - force the window's outer ring to white.
// Rev     : 1.0 - initial release
//==============================================================================
module load_frame
  import load_frame_pkg::*;
#(
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int FS_X    = c_FS_X_DEFAULT,
  parameter int FS_Y    = c_FS_Y_DEFAULT,
  parameter int RD_LAT  = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [12:0] iX,
  input  logic [12:0] iY,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  input  logic        iStart,
  input  logic        iStop,
  input  logic        iMode,
  output logic [14:0] oMemAddr,
  output logic        oMemRE,
  input  logic [7:0]  iMemData,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oInWin,
  output logic        oBusy,
  output logic        oDone,
  output logic [7:0]  oFrameCount
);

  localparam int         c_DLY_DEPTH  = 1 + RD_LAT;
  localparam logic [1:0] c_FLUSH_LAST = 2'(RD_LAT);
`ifdef LOAD_FRAME_BORDER_EN
  localparam int         c_DLY_WIDTH  = 32;
`else
  localparam int         c_DLY_WIDTH  = 31;
`endif

  lfState_t   r_state;
  lfState_t   w_nextState;
  logic       r_stopReq;
  logic [1:0] r_flushCnt;
  logic       w_clearCount;
  logic       w_incCount;
  logic       w_done;

  logic       w_inWin;
  logic       w_frameStart;
  logic       w_readReq;
  logic [12:0] w_dx;
  logic [12:0] w_dy;
  logic [14:0] w_addr;

  logic [c_DLY_WIDTH-1:0] w_dlyIn;
  logic [c_DLY_WIDTH-1:0] w_dlyOut;
  logic       w_dlyRead;
  logic [9:0] w_dlyRed;
  logic [9:0] w_dlyGreen;
  logic [9:0] w_dlyBlue;

  assign w_inWin = (iX >= 13'(H_START)) && (iX <= 13'(H_START + H_RES - 1)) &&
                   (iY >= 13'(V_START)) && (iY <= 13'(V_START + V_RES - 1));
  assign w_frameStart = (iX == 13'(FS_X)) && (iY == 13'(FS_Y));
  assign w_readReq    = (r_state == ST_PLAY) && w_inWin;

  // Modulo-2^15 arithmetic gives the same result as truncating the full sum.
  assign w_dx   = iX - 13'(H_START);
  assign w_dy   = iY - 13'(V_START);
  assign w_addr = 15'(w_dx) + 15'(H_RES) * 15'(w_dy);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oMemAddr <= '0;
      oMemRE   <= 1'b0;
    end else begin
      oMemRE <= w_readReq;
      if (w_readReq) begin
        oMemAddr <= w_addr;
      end
    end
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_clearCount = 1'b0;
    w_incCount   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_nextState  = ST_ARMED;
          w_clearCount = 1'b1;
        end
      end
      ST_ARMED: begin
        if (iStop) begin
          w_nextState = ST_IDLE;
        end else if (w_frameStart) begin
          w_nextState = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_frameStart) begin
          w_incCount = 1'b1;
          if (!iMode || iStop || r_stopReq) begin
            w_nextState = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (r_flushCnt == c_FLUSH_LAST) begin
          w_nextState = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_stopReq   <= 1'b0;
      r_flushCnt  <= '0;
      oDone       <= 1'b0;
      oFrameCount <= '0;
    end else begin
      // A stop seen mid-frame waits for the next frame boundary.
      if ((r_state == ST_PLAY) && (w_nextState == ST_PLAY)) begin
        r_stopReq <= r_stopReq | iStop;
      end else begin
        r_stopReq <= 1'b0;
      end
      r_flushCnt <= (r_state == ST_FLUSH) ? r_flushCnt + 2'd1 : 2'd0;
      oDone      <= w_done;
      if (w_clearCount) begin
        oFrameCount <= '0;
      end else if (w_incCount && (oFrameCount != 8'hFF)) begin
        oFrameCount <= oFrameCount + 8'd1;
      end
    end
  end

  assign oBusy = (r_state != ST_IDLE);

  // ------------------------------------------------------- video alignment
`ifdef LOAD_FRAME_BORDER_EN
  logic w_border;
  logic w_dlyBorder;
  assign w_border = w_inWin &&
                    ((iX == 13'(H_START)) || (iX == 13'(H_START + H_RES - 1)) ||
                     (iY == 13'(V_START)) || (iY == 13'(V_START + V_RES - 1)));
  assign w_dlyIn     = {w_readReq, w_border, iRed, iGreen, iBlue};
  assign w_dlyBorder = w_dlyOut[30];
`else
  assign w_dlyIn = {w_readReq, iRed, iGreen, iBlue};
`endif

  lf_delay_line #(
    .WIDTH (c_DLY_WIDTH),
    .DEPTH (c_DLY_DEPTH)
  ) u_align (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iD     (w_dlyIn),
    .oQ     (w_dlyOut)
  );

  assign w_dlyRead  = w_dlyOut[c_DLY_WIDTH-1];
  assign w_dlyRed   = w_dlyOut[29:20];
  assign w_dlyGreen = w_dlyOut[19:10];
  assign w_dlyBlue  = w_dlyOut[9:0];

  always_comb begin
    oInWin = 1'b0;
    oRed   = w_dlyRed;
    oGreen = w_dlyGreen;
    oBlue  = w_dlyBlue;
    if (w_dlyRead) begin
      oInWin = 1'b1;
      oRed   = grayTo10(iMemData);
      oGreen = grayTo10(iMemData);
      oBlue  = grayTo10(iMemData);
`ifdef LOAD_FRAME_BORDER_EN
      if (w_dlyBorder) begin
        oRed   = c_BORDER_RGB;
        oGreen = c_BORDER_RGB;
        oBlue  = c_BORDER_RGB;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_frame.sv
`default_nettype none
//==============================================================================
// Module  : tb_load_frame
// Desc    : Self-checking bench for load_frame against a frame-level model.
// Rev     : 1.0 - initial release
//==============================================================================
module tb_load_frame;

  localparam int RD_LAT = 2;
  localparam int X0 = 144, Y0 = 35, W = 160, H = 120;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [12:0] iX, iY;
  logic [9:0]  iRed, iGreen, iBlue;
  logic        iStart, iStop, iMode;
  logic [14:0] oMemAddr;
  logic        oMemRE;
  logic [7:0]  iMemData;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oInWin, oBusy, oDone;
  logic [7:0]  oFrameCount;

  always #5 iCLK = ~iCLK;

  load_frame #(.RD_LAT(RD_LAT)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iX(iX), .iY(iY),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iStart(iStart), .iStop(iStop), .iMode(iMode),
    .oMemAddr(oMemAddr), .oMemRE(oMemRE), .iMemData(iMemData),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oInWin(oInWin), .oBusy(oBusy), .oDone(oDone), .oFrameCount(oFrameCount)
  );

  // Synchronous memory returning data RD_LAT cycles after the address.
  logic [7:0] mem [32768];
  logic [7:0] rdPipe [RD_LAT];
  always @(posedge iCLK) begin
    rdPipe[0] <= mem[oMemAddr];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign iMemData = rdPipe[RD_LAT-1];

  typedef struct {
    logic [9:0] r, g, b;
    logic       win;
    int         x, y;
  } pix_t;
  pix_t expQ[$];

  int nTests, nFail;
  int stepIdx, lastFsStep, doneStep, reCount, doneCount, firstAddr, lastAddr;
  int mState, flushLeft;          // 0 idle, 1 armed, 2 playing, 3 flushing
  logic       stopLatched;
  logic [7:0] eCount;
  logic [14:0] eAddr;
  logic       eRE, eDone;

  function automatic logic [9:0] expand(input logic [7:0] m);
    int v;
    v = m;
    return 10'(v * 4 + v / 64);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict everything the DUT shows after the coming clock edge.
  task automatic modelEdge(input int x, input int y, input logic st, input logic sp,
                           input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    pix_t e;
    int   addr;
    logic fs, inw, brd;
    fs   = (x == 143) && (y == 34);
    inw  = (x >= X0) && (x < X0 + W) && (y >= Y0) && (y < Y0 + H);
    brd  = inw && ((x == X0) || (x == X0 + W - 1) || (y == Y0) || (y == Y0 + H - 1));
    addr = (x - X0) + W * (y - Y0);
    e.x = x; e.y = y;
    eRE = (mState == 2) && inw;
    e.win = eRE;
    e.r = r; e.g = g; e.b = b;
    if (eRE) begin
      eAddr = 15'(addr);
      e.r = expand(mem[addr]);
`ifdef LOAD_FRAME_BORDER_EN
      if (brd) e.r = 10'h3FF;
`endif
      e.g = e.r; e.b = e.r;
    end
    expQ.push_back(e);
    if (fs) lastFsStep = stepIdx;
    eDone = 1'b0;
    case (mState)
      0: if (st) begin mState = 1; eCount = 8'd0; end
      1: if (sp) mState = 0; else if (fs) mState = 2;
      2: begin
        if (fs) begin
          if (eCount != 8'hFF) eCount = eCount + 8'd1;
          if (!(iMode && !sp && !stopLatched)) begin
            mState = 3; flushLeft = 1 + RD_LAT; stopLatched = 1'b0;
          end
        end else if (sp) begin
          stopLatched = 1'b1;
        end
      end
      default: begin
        flushLeft--;
        if (flushLeft == 0) begin mState = 0; eDone = 1'b1; end
      end
    endcase
  endtask

  task automatic checkOutputs();
    pix_t e;
    e = expQ.pop_front();
    check("pix_rgb", {oRed, oGreen, oBlue}, {e.r, e.g, e.b});
    check("pix_win", oInWin, e.win);
    check("mem_re", oMemRE, eRE);
    check("mem_addr", oMemAddr, eAddr);
    check("busy", oBusy, mState != 0);
    check("done", oDone, eDone);
    check("frame_count", oFrameCount, eCount);
    if (e.x == 143 && e.y == 35) check("live_143_35", oInWin, 1'b0);
`ifdef LOAD_FRAME_BORDER_EN
    if (e.win && ((e.x == 144 && e.y == 35) || (e.x == 303 && e.y == 100) ||
                  (e.x == 200 && e.y == 154)))
      check("border_px", {oRed, oGreen, oBlue}, {10'h3FF, 10'h3FF, 10'h3FF});
`else
    if (e.win && e.x == 149 && e.y == 35) check("lat_a5", oRed, 10'h296);
`endif
    if (oMemRE) begin
      if (reCount == 0) firstAddr = oMemAddr;
      lastAddr = oMemAddr;
      reCount++;
    end
    if (oDone) begin doneCount++; doneStep = stepIdx; end
  endtask

  task automatic step(input int x, input int y, input logic st, input logic sp);
    logic [9:0] r, g, b;
    @(negedge iCLK);
    stepIdx++;
    checkOutputs();
    r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
    iX = 13'(x); iY = 13'(y); iRed = r; iGreen = g; iBlue = b;
    iStart = st; iStop = sp;
    modelEdge(x, y, st, sp, r, g, b);
  endtask

  task automatic randPix(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(306, 140);
      y = $urandom_range(156, 33);
      if (x == 143 && y == 34) y = 35;
      step(x, y, 1'b0, 1'b0);
    end
  endtask

  task automatic doReset();
    pix_t z;
    @(negedge iCLK);
    iRST_N = 1'b0;
    iX = '0; iY = '0; iRed = '0; iGreen = '0; iBlue = '0; iStart = 1'b0; iStop = 1'b0;
    #1;
    check("rst_rgb", {oRed, oGreen, oBlue}, 32'd0);
    check("rst_inwin", oInWin, 1'b0);
    check("rst_re", oMemRE, 1'b0);
    check("rst_addr", oMemAddr, 15'd0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_count", oFrameCount, 8'd0);
    z.r = '0; z.g = '0; z.b = '0; z.win = 1'b0; z.x = 0; z.y = 0;
    expQ.delete();
    repeat (RD_LAT) expQ.push_back(z);
    mState = 0; flushLeft = 0; stopLatched = 1'b0;
    eCount = '0; eAddr = '0; eRE = 1'b0; eDone = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    modelEdge(0, 0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
  endtask

  initial begin
    nTests = 0; nFail = 0; stepIdx = 0; lastFsStep = 0; doneStep = 0;
    reCount = 0; doneCount = 0; firstAddr = -1; lastAddr = -1;
    iRST_N = 1'b0; iMode = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA5;
    doReset();

    // Single frame, full window scan.
    iMode = 1'b0;
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b0);
    step(10, 10, 1'b0, 1'b0);
    reCount = 0; doneCount = 0;
    step(143, 34, 1'b0, 1'b0);
    for (int y = 35; y <= 154; y++)
      for (int x = 143; x <= 304; x++) step(x, y, 1'b0, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    repeat (8) step(0, 0, 1'b0, 1'b0);
    check("a_re_cycles", reCount, 19200);
    check("a_first_addr", firstAddr, 0);
    check("a_last_addr", lastAddr, 19199);
    check("a_frame_count", oFrameCount, 8'd1);
    check("a_done_count", doneCount, 1);
    check("a_done_latency", doneStep - lastFsStep - 1, 3);

    // Continuous mode: arm on a frame-start cycle, ignored start, mid-frame stop.
    iMode = 1'b1; reCount = 0; doneCount = 0;
    step(143, 34, 1'b1, 1'b0);
    randPix(40);
    step(0, 0, 1'b0, 1'b0);
    check("b_no_early_re", reCount, 0);
    step(143, 34, 1'b0, 1'b0); randPix(100);
    step(143, 34, 1'b0, 1'b0); randPix(50);
    step(200, 60, 1'b1, 1'b0); randPix(50);
    step(143, 34, 1'b0, 1'b0); randPix(50);
    step(210, 90, 1'b0, 1'b1); randPix(50);
    step(143, 34, 1'b0, 1'b0);
    repeat (8) step(0, 0, 1'b0, 1'b0);
    check("b_frame_count", oFrameCount, 8'd3);
    check("b_done_count", doneCount, 1);
    check("b_done_latency", doneStep - lastFsStep - 1, 3);

    // Abort while armed.
    iMode = 1'b0; reCount = 0; doneCount = 0;
    step(0, 0, 1'b1, 1'b0);
    step(5, 5, 1'b0, 1'b0);
    step(6, 6, 1'b0, 1'b1);
    step(7, 7, 1'b0, 1'b0);
    check("c_idle_after_stop", oBusy, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    randPix(40);
    repeat (4) step(0, 0, 1'b0, 1'b0);
    check("c_no_re", reCount, 0);
    check("c_no_done", doneCount, 0);

    // Reset in the middle of playback, then a clean single frame.
    doneCount = 0;
    step(0, 0, 1'b1, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    for (int y = 35; y <= 80; y++) step(200, y, 1'b0, 1'b0);
    doReset();
    step(0, 0, 1'b1, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    randPix(60);
    step(143, 34, 1'b0, 1'b0);
    repeat (8) step(0, 0, 1'b0, 1'b0);
    check("d_frame_count", oFrameCount, 8'd1);
    check("d_done_count", doneCount, 1);
    check("d_done_latency", doneStep - lastFsStep - 1, 3);

    // Window edges versus interior.
    step(0, 0, 1'b1, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    step(144, 35, 1'b0, 1'b0);
    step(303, 100, 1'b0, 1'b0);
    step(200, 154, 1'b0, 1'b0);
    step(200, 100, 1'b0, 1'b0);
    step(145, 36, 1'b0, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    repeat (8) step(0, 0, 1'b0, 1'b0);

    // Frame counter saturation.
    iMode = 1'b1;
    step(0, 0, 1'b1, 1'b0);
    step(143, 34, 1'b0, 1'b0);
    for (int f = 0; f < 260; f++) begin
      step(143, 34, 1'b0, 1'b0);
      randPix(2);
    end
    step(200, 100, 1'b0, 1'b1);
    step(143, 34, 1'b0, 1'b0);
    repeat (8) step(0, 0, 1'b0, 1'b0);
    check("f_count_saturated", oFrameCount, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
